// File: rtl/seq_div24.sv
// ---------------------------------------------------------------------------
// seq_div24 -- sequential restoring divider, one quotient bit per clock.
//
// Divides an unsigned 2*WIDTH-bit dividend by an unsigned WIDTH-bit divisor
// and produces a WIDTH-bit quotient and remainder. A zero divisor or a
// quotient that cannot fit in WIDTH bits is flagged one cycle after accept
// without iterating. Otherwise the result appears WIDTH cycles after accept.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands a/b are valid
//   in_ready   block can accept operands (IDLE only)
//   a          unsigned dividend, 2*WIDTH bits
//   b          unsigned divisor, WIDTH bits
//   out_valid  q/r/div0/ovf are valid (DONE only)
//   out_ready  consumer accepts the result
//   q          quotient (all ones on div0/ovf)
//   r          remainder (a[WIDTH-1:0] on div0, 0 on ovf)
//   div0       divisor was zero
//   ovf        quotient overflow: a[2W-1:W] >= b with b != 0
// ---------------------------------------------------------------------------
module seq_div24 #(
  parameter int WIDTH = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   r,
  output logic               div0,
  output logic               ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   rem_r;     // partial remainder, always < b_r between steps
  logic [WIDTH-1:0]   shreg_r;   // dividend low bits out at the top, quotient bits in at the bottom
  logic [WIDTH-1:0]   b_r;
  logic [CW-1:0]      cnt_r;
  logic               pend_r;    // special-case result captured, DONE on the next edge

  logic [WIDTH:0]     shifted_s;
  logic               ge_s;
  logic [WIDTH-1:0]   next_rem_s;
  logic [WIDTH-1:0]   next_shreg_s;
  logic               accept_s;
  logic               is_div0_s;
  logic               is_ovf_s;

  // One restoring-division step on the registered partial remainder.
  // The shifted value needs WIDTH+1 bits; after a subtraction the true
  // result is < b, so the WIDTH-bit modular difference is exact.
  always_comb begin
    shifted_s    = {rem_r, shreg_r[WIDTH-1]};
    ge_s         = shifted_s[WIDTH] | (shifted_s[WIDTH-1:0] >= b_r);
    if (ge_s) begin
      next_rem_s = shifted_s[WIDTH-1:0] - b_r;
    end else begin
      next_rem_s = shifted_s[WIDTH-1:0];
    end
    next_shreg_s = {shreg_r[WIDTH-2:0], ge_s};
  end

  // Operand handshake and special-case classification of the raw inputs.
  always_comb begin
    accept_s  = in_valid & in_ready;
    is_div0_s = (b == {WIDTH{1'b0}});
    is_ovf_s  = ~is_div0_s & (a[2*WIDTH-1:WIDTH] >= b);
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      q         <= {WIDTH{1'b0}};
      r         <= {WIDTH{1'b0}};
      div0      <= 1'b0;
      ovf       <= 1'b0;
      rem_r     <= {WIDTH{1'b0}};
      shreg_r   <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      cnt_r     <= CNT_ZERO;
      pend_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pend_r) begin
            pend_r    <= 1'b0;
            state_r   <= DONE;
            out_valid <= 1'b1;
          end else if (accept_s) begin
            in_ready <= 1'b0;
            b_r      <= b;
            if (is_div0_s) begin
              q      <= {WIDTH{1'b1}};
              r      <= a[WIDTH-1:0];
              div0   <= 1'b1;
              ovf    <= 1'b0;
              pend_r <= 1'b1;
            end else if (is_ovf_s) begin
              q      <= {WIDTH{1'b1}};
              r      <= {WIDTH{1'b0}};
              div0   <= 1'b0;
              ovf    <= 1'b1;
              pend_r <= 1'b1;
            end else begin
              rem_r   <= a[2*WIDTH-1:WIDTH];
              shreg_r <= a[WIDTH-1:0];
              cnt_r   <= CNT_ZERO;
              state_r <= CALC;
            end
          end
        end
        CALC: begin
          rem_r   <= next_rem_s;
          shreg_r <= next_shreg_s;
          cnt_r   <= cnt_r + CNT_ONE;
          if (cnt_r == LAST_ITER) begin
            // Last step: publish the result straight from the step logic.
            state_r   <= DONE;
            out_valid <= 1'b1;
            q         <= next_shreg_s;
            r         <= next_rem_s;
            div0      <= 1'b0;
            ovf       <= 1'b0;
            cnt_r     <= CNT_ZERO;
          end
        end
        DONE: begin
          // Result holds until taken; in_ready rises only after this edge.
          if (out_ready) begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          pend_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_div24.md
SEQ_DIV24 -- requirements
Module: seq_div24

Interface
REQ-001 SHALL have parameter WIDTH, default 24, divisor/quotient/remainder width; dividend is 2*WIDTH.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port in_valid  input  1  operands valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  2*WIDTH  unsigned dividend (e.g. a 48-bit mantissa product).
REQ-008 SHALL have port b  input  WIDTH  unsigned divisor.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port q  output  WIDTH  quotient.
REQ-012 SHALL have port r  output  WIDTH  remainder.
REQ-013 SHALL have port div0  output  1  divisor was zero.
REQ-014 SHALL have port ovf  output  1  quotient does not fit in WIDTH bits (a[2W-1:W] >= b, b != 0).

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 SHALL accept operands on a rising edge where in_valid & in_ready; a and b are registered internally, and later input changes have no effect.
REQ-017 On accept with b == 0: SHALL go IDLE->DONE; div0=1, ovf=0, q=all ones, r=a[W-1:0].
REQ-018 On accept with b != 0 and a[2W-1:W] >= b: SHALL go IDLE->DONE; ovf=1, div0=0, q=all ones, r=0.
REQ-019 Otherwise SHALL go IDLE->CALC with partial remainder (W+1 bits) = a[2W-1:W], shift register = a[W-1:0], iteration counter = 0.
REQ-020 Each CALC edge: SHALL shift the remainder left by 1, bringing in the next dividend MSB; if the result >= b, subtract b and shift in quotient bit 1, else shift in 0 (restoring division, one bit per cycle).
REQ-021 After exactly WIDTH iterations, SHALL enter DONE with q = floor(a/b), r = a mod b, div0=0, ovf=0; out_valid rises WIDTH edges after the accept edge (24 for default).
REQ-022 Special cases (REQ-017/018): out_valid SHALL rise on the edge after the accept edge.
REQ-023 In DONE, q, r, div0 and ovf SHALL hold stable until out_valid & out_ready; on that edge the FSM returns to IDLE.
REQ-024 SHALL take no new operands in the cycle that a result is accepted; in_ready rises the following cycle.
REQ-025 SHALL never start a new operation while a result is pending, whatever the state of in_valid.
REQ-026 q/r/div0/ovf are don't-care outside DONE; the bench checks them only while out_valid=1.

Reset
REQ-027 rst=1 on an edge SHALL force IDLE, out_valid=0, in_ready=1, q=0, r=0, div0=0, ovf=0, counter=0, from any state including mid-CALC.
REQ-028 rst SHALL take priority over in_valid and out_ready on the same edge, and SHALL discard any in-flight operation.

Verification
REQ-029 a=48'd100, b=24'd7, out_ready=1 -> out_valid 24 cycles after accept; q=14, r=2, div0=0, ovf=0.
REQ-030 a=48'hFFFFFE000001, b=24'hFFFFFF -> q=24'hFFFFFF, r=0; and a=48'h000000FFFFFF, b=24'h000001 -> q=24'hFFFFFF, r=0.
REQ-031 b=0, a=48'h123456789ABC -> out_valid 1 cycle after accept; div0=1, q=24'hFFFFFF, r=24'h789ABC; a=48'h000010000000, b=24'h000010 -> ovf=1, q=24'hFFFFFF, r=0.
REQ-032 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and outputs stable; in_ready=0 throughout CALC/DONE even with in_valid=1; after the accept edge, in_ready=1 next cycle and back-to-back ops give correct results.
REQ-033 Reset at CALC iteration 10 -> next cycle: in_ready=1, out_valid=0, all outputs 0; a new op a=48'd100, b=24'd7 then completes with q=14, r=2.
REQ-034 Random: 10k random a/b with a[47:24] < b, b != 0 -> q*b + r == a and r < b for every result.
